// File: rtl/decoder_3x8_seq.sv
// rtl/decoder_3x8_seq.sv - sequential 3-to-8 decoder with 2-entry input FIFO and timed one-hot pulses
//
// Purpose: accepts 3-bit codes over a valid/ready handshake, buffers up to two,
// and replays each as a one-hot strobe on y for PULSE_LEN enabled cycles,
// followed by GAP_LEN idle cycles.
//
// Parameters:
//   PULSE_LEN  cycles each one-hot output is held (1..255)
//   GAP_LEN    idle cycles after each pulse (0..255)
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   a        in   [2:0] code to decode
//   a_valid  in   a is valid this cycle
//   a_ready  out  FIFO can accept (count != 2)
//   en       in   run enable; low freezes the FSM and blanks y/v/done
//   y        out  [7:0] one-hot decoded output, zero when idle
//   v        out  y carries a valid code
//   done     out  last cycle of each pulse
//   busy     out  FSM active or FIFO non-empty

module decoder_3x8_seq #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] a,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic       en,
    output logic [7:0] y,
    output logic       v,
    output logic       done,
    output logic       busy
);

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_LOAD   = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;
    localparam bit         HAS_GAP    = (GAP_LEN > 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] y_reg;
    logic       v_reg;

    logic [2:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic       fifo_empty;
    logic [2:0] head;

    // Ready depends only on the registered count, so a same-cycle pop never
    // opens the door for a push into a full FIFO.
    assign a_ready    = (count != 2'd2);
    assign push       = a_valid && a_ready;
    assign fifo_empty = (count == 2'd0);
    assign head       = mem[rd_ptr];

    always_comb begin
        pop = 1'b0;
        if (en) begin
            case (state)
                IDLE:    pop = !fifo_empty;
                DRIVE:   pop = (cnt == 8'd0) && !HAS_GAP && !fifo_empty;
                default: pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= 3'd0;
            mem[1] <= 3'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= a;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            y_reg <= 8'd0;
            v_reg <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        y_reg <= 8'd1 << head;
                        v_reg <= 1'b1;
                        cnt   <= PULSE_LOAD;
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (HAS_GAP) begin
                        y_reg <= 8'd0;
                        v_reg <= 1'b0;
                        cnt   <= GAP_LOAD;
                        state <= GAP;
                    end else if (!fifo_empty) begin
                        // Zero gap: chain straight into the next code, v stays high.
                        y_reg <= 8'd1 << head;
                        cnt   <= PULSE_LOAD;
                    end else begin
                        y_reg <= 8'd0;
                        v_reg <= 1'b0;
                        state <= IDLE;
                    end
                end
                GAP: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Enable gates the visible outputs without disturbing the held pulse.
    assign y    = en ? y_reg : 8'd0;
    assign v    = en && v_reg;
    assign done = en && (state == DRIVE) && (cnt == 8'd0);
    assign busy = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_decoder_3x8_seq.sv
// tb/tb_decoder_3x8_seq.sv - directed self-checking bench for decoder_3x8_seq

module tb_decoder_3x8_seq;

    logic       clk;
    logic       rst;

    logic [2:0] a0;
    logic       av0;
    logic       en0;
    logic       ar0;
    logic [7:0] y0;
    logic       v0;
    logic       done0;
    logic       busy0;

    logic [2:0] a1;
    logic       av1;
    logic       en1;
    logic       ar1;
    logic [7:0] y1;
    logic       v1;
    logic       done1;
    logic       busy1;

    int checks;
    int errors;

    logic [7:0] ylog [$];
    logic       v0_prev;
    logic       saw_full;
    int         vcount;

    decoder_3x8_seq #(.PULSE_LEN(4), .GAP_LEN(1)) dut0 (
        .clk(clk), .rst(rst), .a(a0), .a_valid(av0), .a_ready(ar0), .en(en0),
        .y(y0), .v(v0), .done(done0), .busy(busy0)
    );

    decoder_3x8_seq #(.PULSE_LEN(1), .GAP_LEN(0)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .a_valid(av1), .a_ready(ar1), .en(en1),
        .y(y1), .v(v1), .done(done1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (v0 && !v0_prev) ylog.push_back(y0);
        v0_prev = v0;
        if (!ar0) saw_full = 1'b1;
        if (v0) vcount = vcount + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int guard;
        logic timed_out;
        checks    = 0;
        errors    = 0;
        v0_prev   = 1'b0;
        saw_full  = 1'b0;
        vcount    = 0;
        timed_out = 1'b0;
        rst = 1'b1;
        a0 = 3'd7; av0 = 1'b1; en0 = 1'b1;
        a1 = 3'd0; av1 = 1'b0; en1 = 1'b1;

        // Handshakes during reset are ignored
        step(); step();
        chk("rst_y", 32'(y0), 32'h00);
        chk("rst_v", 32'(v0), 32'h0);
        chk("rst_done", 32'(done0), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_ready", 32'(ar0), 32'h1);
        av0 = 1'b0;
        rst = 1'b0;
        step();
        chk("post_rst_busy", 32'(busy0), 32'h0);
        chk("post_rst_y", 32'(y0), 32'h00);

        // Single code 5: 4 drive cycles, done on the 4th, gap, then idle
        a0 = 3'd5; av0 = 1'b1;
        step();
        av0 = 1'b0;
        chk("t1_accept_busy", 32'(busy0), 32'h1);
        chk("t1_accept_v", 32'(v0), 32'h0);
        step(); chk("t1_c1_y", 32'(y0), 32'h20); chk("t1_c1_v", 32'(v0), 32'h1); chk("t1_c1_done", 32'(done0), 32'h0);
        step(); chk("t1_c2_y", 32'(y0), 32'h20); chk("t1_c2_done", 32'(done0), 32'h0);
        step(); chk("t1_c3_y", 32'(y0), 32'h20); chk("t1_c3_done", 32'(done0), 32'h0);
        step(); chk("t1_c4_y", 32'(y0), 32'h20); chk("t1_c4_done", 32'(done0), 32'h1);
        step(); chk("t1_gap_y", 32'(y0), 32'h00); chk("t1_gap_v", 32'(v0), 32'h0); chk("t1_gap_busy", 32'(busy0), 32'h1);
        step(); chk("t1_idle_busy", 32'(busy0), 32'h0); chk("t1_idle_y", 32'(y0), 32'h00);

        // en low for 3 cycles after the 2nd drive cycle of code 2
        a0 = 3'd2; av0 = 1'b1;
        step();
        av0 = 1'b0;
        step(); chk("en_c1_y", 32'(y0), 32'h04);
        step(); chk("en_c2_y", 32'(y0), 32'h04);
        step();
        en0 = 1'b0;
        #1;
        chk("en_off_y", 32'(y0), 32'h00);
        chk("en_off_v", 32'(v0), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("en_frozen_y", 32'(y0), 32'h00);
            chk("en_frozen_done", 32'(done0), 32'h0);
        end
        en0 = 1'b1;
        #1;
        chk("en_c3_y", 32'(y0), 32'h04); chk("en_c3_done", 32'(done0), 32'h0);
        step(); chk("en_c4_y", 32'(y0), 32'h04); chk("en_c4_done", 32'(done0), 32'h1);
        step(); chk("en_end_y", 32'(y0), 32'h00); chk("en_end_v", 32'(v0), 32'h0);
        step(); step();
        chk("en_idle_busy", 32'(busy0), 32'h0);

        // Full sweep 0..7 with a_valid held, ready-gated
        ylog.delete();
        saw_full = 1'b0;
        for (int code = 0; code < 8; code++) begin
            a0 = 3'(code);
            av0 = 1'b1;
            guard = 0;
            while (!ar0 && guard < 100) begin
                step();
                guard = guard + 1;
            end
            if (guard >= 100) timed_out = 1'b1;
            step();
        end
        av0 = 1'b0;
        for (int i = 0; i < 60; i++) step();
        chk("sweep_timeout", 32'(timed_out), 32'h0);
        chk("sweep_count", 32'(ylog.size()), 32'd8);
        chk("sweep_full_seen", 32'(saw_full), 32'h1);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] got;
            got = (i < ylog.size()) ? ylog[i] : 8'hxx;
            chk($sformatf("sweep_y%0d", i), 32'(got), 32'(8'd1 << i));
        end
        chk("sweep_idle_busy", 32'(busy0), 32'h0);

        // Zero-gap, single-cycle pulses chain back to back
        a1 = 3'd3; av1 = 1'b1;
        step();
        a1 = 3'd6;
        step(); chk("bb_y3", 32'(y1), 32'h08); chk("bb_v3", 32'(v1), 32'h1); chk("bb_d3", 32'(done1), 32'h1);
        a1 = 3'd1;
        step(); chk("bb_y6", 32'(y1), 32'h40); chk("bb_v6", 32'(v1), 32'h1);
        av1 = 1'b0;
        step(); chk("bb_y1", 32'(y1), 32'h02); chk("bb_v1", 32'(v1), 32'h1);
        step(); chk("bb_end_y", 32'(y1), 32'h00); chk("bb_end_v", 32'(v1), 32'h0); chk("bb_end_busy", 32'(busy1), 32'h0);

        // Reset mid-pulse with two codes queued
        a0 = 3'd1; av0 = 1'b1;
        step();
        a0 = 3'd3;
        step();
        a0 = 3'd4;
        step();
        av0 = 1'b0;
        chk("mid_full_ready", 32'(ar0), 32'h0);
        chk("mid_active_y", 32'(y0), 32'h02);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_y", 32'(y0), 32'h00);
        chk("mid_rst_v", 32'(v0), 32'h0);
        chk("mid_rst_ready", 32'(ar0), 32'h1);
        step();
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 20; i++) step();
        chk("mid_no_residual", 32'(vcount), 32'd0);
        chk("mid_after_ready", 32'(ar0), 32'h1);
        chk("mid_after_busy", 32'(busy0), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
